// File: rtl/ppu_pkg.sv
// Shared PPU datapath definitions: control-word layout and fixed register numbers.
package ppu_pkg;
    localparam int CW_W = 22;

    localparam int CW_COND    = 21;
    localparam int CW_R31     = 20;
    localparam int CW_UNCOND  = 19;
    localparam int CW_DEST    = 18;
    localparam int CW_SRC_HI  = 17;
    localparam int CW_SRC_LO  = 15;
    localparam int CW_ALU_HI  = 14;
    localparam int CW_ALU_LO  = 11;
    localparam int CW_LOAD    = 10;
    localparam int CW_RF_EN   = 9;
    localparam int CW_B       = 8;
    localparam int CW_TA      = 7;
    localparam int CW_SIZE_HI = 6;
    localparam int CW_SIZE_LO = 5;
    localparam int CW_MEM_RW  = 4;
    localparam int CW_SE      = 3;
    localparam int CW_HI      = 2;
    localparam int CW_LO      = 1;
    localparam int CW_MEM_EN  = 0;

    localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/load_use_detect.sv
// Flags a load-use hazard: EX holds a memory read whose destination is a source of ID.
module load_use_detect #(
    parameter int CW_W = ppu_pkg::CW_W
) (
    input  logic [CW_W-1:0] ex_control,
    input  logic [4:0]      ex_dest,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            id_valid,
    output logic            hazard
);
    import ppu_pkg::*;

    logic [4:0] src [2];
    logic [1:0] src_match;
    logic       ex_mem_read;

    assign src[0] = id_rs;
    assign src[1] = id_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = (ex_dest == src[gi]);
        end
    endgenerate

    assign ex_mem_read = ex_control[CW_MEM_EN] & ~ex_control[CW_MEM_RW] & ex_control[CW_RF_EN];
    assign hazard      = ex_mem_read & (ex_dest != 5'd0) & (|src_match) & id_valid;
endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash and bubble counter.
module id_ex_stage_register #(
    parameter int CW_W  = ppu_pkg::CW_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CW_W-1:0]  id_control,
    input  logic [31:0]      id_instruction,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_rs_val,
    input  logic [31:0]      id_rt_val,
    input  logic             ex_flush,
    output logic [CW_W-1:0]  ex_control,
    output logic [31:0]      ex_instruction,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rs_val,
    output logic [31:0]      ex_rt_val,
    output logic [4:0]       ex_dest_reg,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_count
);
    import ppu_pkg::*;

    logic [CW_W-1:0]  ex_control_reg, ex_control_next;
    logic [31:0]      ex_instruction_reg, ex_instruction_next;
    logic [31:0]      ex_pc_reg, ex_pc_next;
    logic [31:0]      ex_rs_val_reg, ex_rs_val_next;
    logic [31:0]      ex_rt_val_reg, ex_rt_val_next;
    logic [4:0]       ex_dest_reg_reg, ex_dest_reg_next;
    logic [CNT_W-1:0] bubble_count_reg, bubble_count_next;
    logic [4:0]       id_dest;
    logic             hazard;
    logic             bubble;

    always_comb begin
        unique case ({id_control[CW_DEST], id_control[CW_R31]})
            2'b10:   id_dest = id_instruction[15:11];
            2'b11:   id_dest = id_instruction[20:16];
            2'b01:   id_dest = REG_RA;
            default: id_dest = 5'd0;
        endcase
        if (!id_control[CW_RF_EN]) begin
            id_dest = 5'd0;
        end
    end

    load_use_detect #(.CW_W(CW_W)) u_load_use_detect (
        .ex_control (ex_control_reg),
        .ex_dest    (ex_dest_reg_reg),
        .id_rs      (id_instruction[25:21]),
        .id_rt      (id_instruction[20:16]),
        .id_valid   (|id_control),
        .hazard     (hazard)
    );

    // A flush already empties the slot, so it overrides the stall request.
    assign stall  = hazard & ~ex_flush;
    assign bubble = ex_flush | stall;

    always_comb begin
        ex_control_next     = id_control;
        ex_instruction_next = id_instruction;
        ex_dest_reg_next    = id_dest;
        ex_pc_next          = id_pc;
        ex_rs_val_next      = id_rs_val;
        ex_rt_val_next      = id_rt_val;
        bubble_count_next   = bubble_count_reg;
        if (bubble) begin
            ex_control_next     = '0;
            ex_instruction_next = '0;
            ex_dest_reg_next    = '0;
            if (bubble_count_reg != '1) begin
                bubble_count_next = bubble_count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_control_reg     <= '0;
            ex_instruction_reg <= '0;
            ex_pc_reg          <= '0;
            ex_rs_val_reg      <= '0;
            ex_rt_val_reg      <= '0;
            ex_dest_reg_reg    <= '0;
            bubble_count_reg   <= '0;
        end else begin
            ex_control_reg     <= ex_control_next;
            ex_instruction_reg <= ex_instruction_next;
            ex_pc_reg          <= ex_pc_next;
            ex_rs_val_reg      <= ex_rs_val_next;
            ex_rt_val_reg      <= ex_rt_val_next;
            ex_dest_reg_reg    <= ex_dest_reg_next;
            bubble_count_reg   <= bubble_count_next;
        end
    end

    assign ex_control     = ex_control_reg;
    assign ex_instruction = ex_instruction_reg;
    assign ex_pc          = ex_pc_reg;
    assign ex_rs_val      = ex_rs_val_reg;
    assign ex_rt_val      = ex_rt_val_reg;
    assign ex_dest_reg    = ex_dest_reg_reg;
    assign bubble_count   = bubble_count_reg;
endmodule

// File: tb/tb_id_ex_stage_register.sv
// Randomized and directed checks of the ID/EX stage against a cycle-level reference model.
module tb_id_ex_stage_register;
    localparam int CW_W  = 22;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [21:0] C_SUBU  = 22'h040A00;
    localparam logic [21:0] C_JAL   = 22'h380200;
    localparam logic [21:0] C_ADDIU = 22'h148200;
    localparam logic [21:0] C_LBU   = 22'h140601;
    localparam logic [21:0] C_LWRD  = 22'h040601;
    localparam logic [21:0] C_SB    = 22'h000011;

    logic             clk = 1'b0;
    logic             reset;
    logic [CW_W-1:0]  id_control;
    logic [31:0]      id_instruction, id_pc, id_rs_val, id_rt_val;
    logic             ex_flush;
    logic [CW_W-1:0]  ex_control;
    logic [31:0]      ex_instruction, ex_pc, ex_rs_val, ex_rt_val;
    logic [4:0]       ex_dest_reg;
    logic             stall;
    logic [CNT_W-1:0] bubble_count;

    always #5 clk = ~clk;

    id_ex_stage_register #(.CW_W(CW_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_control     (id_control),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_rs_val      (id_rs_val),
        .id_rt_val      (id_rt_val),
        .ex_flush       (ex_flush),
        .ex_control     (ex_control),
        .ex_instruction (ex_instruction),
        .ex_pc          (ex_pc),
        .ex_rs_val      (ex_rs_val),
        .ex_rt_val      (ex_rt_val),
        .ex_dest_reg    (ex_dest_reg),
        .stall          (stall),
        .bubble_count   (bubble_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference EX state
    logic [21:0] m_ctrl;
    logic [31:0] m_instr, m_pc, m_rs, m_rt;
    logic [4:0]  m_dest;
    int          m_cnt;
    bit          stall_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] dest_of(input logic [21:0] c, input logic [31:0] ins);
        if (!c[9])       return 5'd0;
        if (c[18] && !c[20]) return ins[15:11];
        if (c[18] && c[20])  return ins[20:16];
        if (!c[18] && c[20]) return 5'd31;
        return 5'd0;
    endfunction

    function automatic bit load_use(input logic [21:0] exc, input logic [4:0] exd,
                                    input logic [21:0] idc, input logic [31:0] ins);
        bit is_load;
        is_load = (exc[0] == 1'b1) && (exc[4] == 1'b0) && (exc[9] == 1'b1);
        return is_load && (exd != 0) && (idc != 0) &&
               ((exd == ins[25:21]) || (exd == ins[20:16]));
    endfunction

    function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
        logic [31:0] w;
        w = 32'h0;
        w[25:21] = 5'(rs);
        w[20:16] = 5'(rt);
        w[15:11] = 5'(rd);
        return w;
    endfunction

    task automatic model_clear();
        m_ctrl = '0; m_instr = '0; m_pc = '0; m_rs = '0; m_rt = '0; m_dest = '0; m_cnt = 0;
    endtask

    // One clock: drive ID, compare all outputs before the edge, advance the model.
    task automatic cycle(input logic [21:0] c, input logic [31:0] ins, input bit fl, input bit rst);
        bit exp_stall;
        id_control     = c;
        id_instruction = ins;
        id_pc          = $urandom;
        id_rs_val      = $urandom;
        id_rt_val      = $urandom;
        ex_flush       = fl;
        reset          = rst;
        @(negedge clk);
        exp_stall  = load_use(m_ctrl, m_dest, c, ins) && !fl;
        stall_seen = stall;
        check_val("ex_control", 32'(ex_control), 32'(m_ctrl));
        check_val("ex_instruction", ex_instruction, m_instr);
        check_val("ex_pc", ex_pc, m_pc);
        check_val("ex_rs_val", ex_rs_val, m_rs);
        check_val("ex_rt_val", ex_rt_val, m_rt);
        check_val("ex_dest_reg", 32'(ex_dest_reg), 32'(m_dest));
        check_val("bubble_count", 32'(bubble_count), 32'(m_cnt));
        check_val("stall", 32'(stall), 32'(exp_stall));
        $display("t=%0t rst=%0b fl=%0b id_ctrl=%06h ex_ctrl=%06h dest=%0d stall=%0b cnt=%0d",
                 $time, rst, fl, c, ex_control, ex_dest_reg, stall, bubble_count);
        if (rst) begin
            model_clear();
        end else begin
            m_pc = id_pc; m_rs = id_rs_val; m_rt = id_rt_val;
            if (fl || exp_stall) begin
                m_ctrl = '0; m_instr = '0; m_dest = '0;
                m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end else begin
                m_ctrl = c; m_instr = ins; m_dest = dest_of(c, ins);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [21:0] table_c [8];
    int cnt0;

    initial begin
        table_c = '{C_SUBU, C_JAL, C_ADDIU, C_LBU, C_LWRD, C_SB, 22'h0, C_LBU};

        // Reset held two cycles with busy inputs
        reset = 1'b1; ex_flush = 1'b0;
        id_control = C_LBU; id_instruction = mk(4, 4, 4);
        id_pc = 32'h1234; id_rs_val = 32'hdead; id_rt_val = 32'hbeef;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        cycle(C_LBU, mk(4, 4, 4), 1'b0, 1'b1);
        check_val("rst_stall", 32'(stall_seen), 32'd0);

        // Pass-through destinations
        cycle(C_SUBU, mk(1, 2, 3), 1'b0, 1'b0);
        check_val("subu_ctrl", 32'(ex_control), 32'h040A00);
        check_val("subu_dest", 32'(ex_dest_reg), 32'd3);
        cycle(C_JAL, mk(0, 0, 0), 1'b0, 1'b0);
        check_val("jal_dest", 32'(ex_dest_reg), 32'd31);
        cycle(C_ADDIU, mk(1, 5, 9), 1'b0, 1'b0);
        check_val("addiu_dest", 32'(ex_dest_reg), 32'd5);

        // Load-use: one stall cycle, one bubble, then the held instruction
        cycle(C_LBU, mk(7, 4, 0), 1'b0, 1'b1);
        cycle(C_LBU, mk(7, 4, 0), 1'b0, 1'b0);
        cycle(C_SUBU, mk(4, 2, 3), 1'b0, 1'b0);
        check_val("lu_stall_n", 32'(stall_seen), 32'd1);
        check_val("lu_bubble", 32'(ex_control), 32'd0);
        cycle(C_SUBU, mk(4, 2, 3), 1'b0, 1'b0);
        check_val("lu_stall_n1", 32'(stall_seen), 32'd0);
        check_val("lu_captured", 32'(ex_control), 32'h040A00);
        check_val("lu_count", 32'(bubble_count), 32'd1);

        // No false hazards
        cycle(C_LBU, mk(1, 0, 0), 1'b0, 1'b0);
        cycle(C_SUBU, mk(0, 0, 3), 1'b0, 1'b0);
        check_val("nohz_r0", 32'(stall_seen), 32'd0);
        cycle(C_SB, mk(1, 4, 0), 1'b0, 1'b0);
        cycle(C_SUBU, mk(4, 4, 3), 1'b0, 1'b0);
        check_val("nohz_store", 32'(stall_seen), 32'd0);
        cycle(C_ADDIU, mk(1, 5, 0), 1'b0, 1'b0);
        cycle(C_SUBU, mk(5, 5, 3), 1'b0, 1'b0);
        check_val("nohz_alu", 32'(stall_seen), 32'd0);

        // Flush alone, then flush coinciding with a hazard
        cycle(C_SUBU, mk(1, 2, 3), 1'b1, 1'b0);
        check_val("fl_stall", 32'(stall_seen), 32'd0);
        check_val("fl_ctrl", 32'(ex_control), 32'd0);
        cycle(C_LBU, mk(1, 6, 0), 1'b0, 1'b0);
        cnt0 = int'(bubble_count);
        cycle(C_SUBU, mk(6, 2, 3), 1'b1, 1'b0);
        check_val("flhz_stall", 32'(stall_seen), 32'd0);
        check_val("flhz_ctrl", 32'(ex_control), 32'd0);
        check_val("flhz_count", 32'(bubble_count), 32'(cnt0 + 1));

        // Reset in the middle of a stall
        cycle(C_LBU, mk(1, 6, 0), 1'b0, 1'b0);
        cycle(C_SUBU, mk(6, 2, 3), 1'b0, 1'b1);
        cycle(C_SUBU, mk(6, 2, 3), 1'b0, 1'b0);
        check_val("rst_mid_stall", 32'(stall_seen), 32'd0);

        // Saturation: 2^CNT_W + 3 bubbles
        cycle(22'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            cycle(C_SUBU, mk(1, 2, 3), 1'b1, 1'b0);
        end
        check_val("sat_count", 32'(bubble_count), 32'hF);

        // Randomized traffic; upstream holds ID while stalled
        begin
            logic [21:0] c;
            logic [31:0] ins;
            bit fl, rst;
            c = 22'h0; ins = 32'h0;
            for (int i = 0; i < 400; i++) begin
                if (!stall_seen) begin
                    c   = table_c[$urandom_range(0, 7)];
                    ins = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 11'($urandom)};
                end
                fl  = ($urandom_range(0, 7) == 0);
                rst = ($urandom_range(0, 39) == 0);
                cycle(c, ins, fl, rst);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
